hyperbus_read_ctrl: RTL and testbench
=====================================

HYPERBUS_READ_CTRL -- requirements
Module: hyperbus_read_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of burst length in 16-bit words.
REQ-002 SHALL have parameter TO_W, default 8, width of timeout and flush counters.
REQ-003 SHALL have parameter FLUSH_CYC, default 8, clk0 cycles spent draining the CDC FIFO after an abort.
REQ-004 SHALL have the following ports, clock and reset first:
- clk0  in  1  single system clock; all logic on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  read burst request.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_len_i  in  LEN_W  burst length in words.
- cfg_timeout_i  in  TO_W  max idle cycles between words; 0 disables timeout.
- read_clk_en_o  out  1  gates RWDS capture clock in read datapath.
- rx_valid_i  in  1  CDC FIFO output valid (clk0 side).
- rx_data_i  in  16  CDC FIFO output data.
- rx_ready_o  out  1  pop to CDC FIFO.
- out_valid_o  out  1  word to requester.
- out_data_o  out  16  word data.
- out_last_o  out  1  marks final word of burst.
- out_ready_i  in  1  requester accepts word.
- abort_i  in  1  cancel active burst.
- done_o  out  1  one-cycle pulse, burst ended.
- error_o  out  1  one-cycle pulse with done_o when burst ended by timeout or abort.
REQ-005 Clock is clk0; reset is rst_ni, asynchronous, active-low.

Function
REQ-006 SHALL implement states IDLE, RECV, FLUSH.
REQ-007 IDLE: req_ready_o=1, read_clk_en_o=0, rx_ready_o=0, out_valid_o=0.
REQ-008 IDLE, req_valid_i&&req_len_i!=0: latch len into remaining counter, clear idle counter, go RECV; read_clk_en_o=1 from next cycle.
REQ-009 IDLE, req_valid_i&&req_len_i==0: accept, pulse done_o next cycle (error_o=0), stay IDLE.
REQ-010 RECV: read_clk_en_o=1, req_ready_o=0; datapath is pass-through: out_valid_o=rx_valid_i, out_data_o=rx_data_i, rx_ready_o=out_ready_i (zero latency, combinational).
REQ-011 out_last_o SHALL be 1 when remaining==1 and out_valid_o=1.
REQ-012 Each transfer (rx_valid_i&&out_ready_i) decrements remaining and clears idle counter.
REQ-013 Transfer with remaining==1: next cycle IDLE, read_clk_en_o=0, done_o=1, error_o=0.
REQ-014 Idle counter increments each RECV cycle without a transfer, saturating at all-ones.
REQ-015 abort_i in RECV (priority over transfer in same cycle; that word not consumed) -> FLUSH.
REQ-016 FLUSH: read_clk_en_o=0, out_valid_o=0, rx_ready_o=1 (words discarded), flush counter counts FLUSH_CYC cycles, then IDLE with done_o=1 and error_o=1 in that cycle.
REQ-017 abort_i in IDLE or FLUSH SHALL be ignored.
REQ-018 remaining counter SHALL never underflow; words arriving in IDLE are left in the FIFO (rx_ready_o=0).

Reset
REQ-019 On rst_ni low: state IDLE, counters 0, read_clk_en_o=0, done_o=0, error_o=0, out_valid_o=0, rx_ready_o=0, req_ready_o=0 until reset release.
REQ-020 Reset asserted mid-burst SHALL immediately drop read_clk_en_o; no done_o is generated.

Configuration
REQ-021 Macro HYPERBUS_READ_TIMEOUT_EN: when defined, in RECV idle counter==cfg_timeout_i with cfg_timeout_i!=0 -> FLUSH, same as abort.
REQ-022 Without HYPERBUS_READ_TIMEOUT_EN: no idle counter logic; cfg_timeout_i unused; only abort_i exits RECV early.

Structure
REQ-023 State enum type and default LEN_W/TO_W constants SHALL live in hyperbus_pkg.
REQ-024 No sub-modules; single flat FSM plus counters.

Verification
REQ-025 req_len=4, rx words 0x1111..0x4444, out_ready=1 -> 4 outputs, last on 0x4444, done_o=1 error_o=0, read_clk_en_o high exactly until after 4th word.
REQ-026 req_len=3 with out_ready toggling 1/0 -> rx_ready_o mirrors out_ready_i, no word lost or duplicated, last on 3rd.
REQ-027 req_len=0 -> done_o pulse one cycle after accept, read_clk_en_o never asserts.
REQ-028 TIMEOUT_EN, cfg_timeout=5, req_len=4, only 2 words arrive -> FLUSH after 5 idle cycles, done_o&error_o after FLUSH_CYC=8 cycles.
REQ-029 abort_i coincident with rx_valid in RECV -> word not forwarded, FLUSH entered, error_o=1.
REQ-030 rst_ni low during word 2 of 4 -> read_clk_en_o=0 immediately, no done_o; new burst after release completes normally.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared types and default sizing for the HyperBus read controller.
// Used by hyperbus_read_ctrl (optional timeout: HYPERBUS_READ_TIMEOUT_EN).
package hyperbus_pkg;

  localparam int unsigned HB_LEN_W     = 16;
  localparam int unsigned HB_TO_W      = 8;
  localparam int unsigned HB_FLUSH_CYC = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2
  } hb_state_e;

endpackage

// File: rtl/hyperbus_read_ctrl.sv
// HyperBus read-burst controller: forwards CDC FIFO words to the requester and drains the FIFO on abort.
// Define HYPERBUS_READ_TIMEOUT_EN to let an idle-word timeout end a burst the same way an abort does.
module hyperbus_read_ctrl
  import hyperbus_pkg::*;
#(
  parameter int unsigned LEN_W     = HB_LEN_W,
  parameter int unsigned TO_W      = HB_TO_W,
  parameter int unsigned FLUSH_CYC = HB_FLUSH_CYC
) (
  input  logic             clk0,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [TO_W-1:0]  cfg_timeout_i,
  output logic             read_clk_en_o,
  input  logic             rx_valid_i,
  input  logic [15:0]      rx_data_i,
  output logic             rx_ready_o,
  output logic             out_valid_o,
  output logic [15:0]      out_data_o,
  output logic             out_last_o,
  input  logic             out_ready_i,
  input  logic             abort_i,
  output logic             done_o,
  output logic             error_o
);

  hb_state_e        state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [TO_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic timeout_hit;
  logic early_exit;
  logic in_recv;
  logic xfer;

  assign in_recv    = (state_q == RECV);
  assign early_exit = in_recv && (abort_i || timeout_hit);
  // An early exit wins over a word offered in the same cycle: that word stays in the FIFO.
  assign xfer       = in_recv && !early_exit && rx_valid_i && out_ready_i;

`ifdef HYPERBUS_READ_TIMEOUT_EN
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

  assign timeout_hit = (cfg_timeout_i != '0) && (idle_cnt_q == cfg_timeout_i);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q == IDLE) && req_valid_i && (req_len_i != '0)) begin
      idle_cnt_d = '0;
    end else if (in_recv) begin
      if (xfer) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q != '1) begin
        idle_cnt_d = idle_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_cfg_timeout;

  assign timeout_hit        = 1'b0;
  assign unused_cfg_timeout = ^cfg_timeout_i;
`endif

  // State register and the registered done/error pulses.
  always_ff @(posedge clk0 or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      remaining_q <= remaining_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d     = state_q;
    remaining_d = remaining_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_len_i != '0) begin
            remaining_d = req_len_i;
            state_d     = RECV;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (early_exit) begin
          flush_cnt_d = '0;
          state_d     = FLUSH;
        end else if (xfer && (remaining_q != '0)) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q >= TO_W'(FLUSH_CYC - 1)) begin
          flush_cnt_d = '0;
          state_d     = IDLE;
          done_d      = 1'b1;
          error_d     = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: zero-latency pass-through while receiving, FIFO drain while flushing.
  always_comb begin
    req_ready_o   = 1'b0;
    read_clk_en_o = 1'b0;
    rx_ready_o    = 1'b0;
    out_valid_o   = 1'b0;
    out_data_o    = '0;
    out_last_o    = 1'b0;
    // NOTE: the request handshake stays closed while reset is held, even though the state already reads IDLE.
    if (rst_ni) begin
      unique case (state_q)
        IDLE: req_ready_o = 1'b1;
        RECV: begin
          read_clk_en_o = 1'b1;
          out_valid_o   = rx_valid_i && !early_exit;
          out_data_o    = rx_data_i;
          rx_ready_o    = out_ready_i && !early_exit;
          out_last_o    = rx_valid_i && !early_exit && (remaining_q == LEN_W'(1));
        end
        FLUSH: rx_ready_o = 1'b1;
        default: req_ready_o = 1'b0;
      endcase
    end
  end

  assign done_o  = done_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_hyperbus_read_ctrl.sv
// Self-checking bench for hyperbus_read_ctrl: queue-modelled CDC FIFO source and an output/done scoreboard.
// Timeout scenario runs when HYPERBUS_READ_TIMEOUT_EN is defined; otherwise the stall must not end the burst.
`timescale 1ns/1ps
module tb_hyperbus_read_ctrl;

  localparam int LEN_W     = 16;
  localparam int TO_W      = 8;
  localparam int FLUSH_CYC = 8;

  logic             clk0 = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [LEN_W-1:0] req_len_i = '0;
  logic [TO_W-1:0]  cfg_timeout_i = '0;
  logic             read_clk_en_o;
  logic             rx_valid_i = 1'b0;
  logic [15:0]      rx_data_i = '0;
  logic             rx_ready_o;
  logic             out_valid_o;
  logic [15:0]      out_data_o;
  logic             out_last_o;
  logic             out_ready_i = 1'b1;
  logic             abort_i = 1'b0;
  logic             done_o;
  logic             error_o;

  hyperbus_read_ctrl #(
    .LEN_W    (LEN_W),
    .TO_W     (TO_W),
    .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk0         (clk0),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_len_i    (req_len_i),
    .cfg_timeout_i(cfg_timeout_i),
    .read_clk_en_o(read_clk_en_o),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .rx_ready_o   (rx_ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .out_ready_i  (out_ready_i),
    .abort_i      (abort_i),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk0 = ~clk0;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] exp_q[$];       // {last, data} expected at the requester
  logic        exp_done_q[$];  // expected error_o for each done_o pulse
  logic [15:0] src_q[$];       // CDC FIFO contents
  logic [16:0] want_word;
  logic        want_err;

  bit src_pop      = 1'b0;
  bit toggle_ready = 1'b0;
  bit chk_mirror   = 1'b0;
  int cyc = 0;
  int done_seen = 0;
  int done_base = 0;
  int last_done_cyc = 0;
  int acc_cyc = 0;
  int clk_en_cnt = 0;
  int mark_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  always @(posedge clk0) cyc <= cyc + 1;

  // Monitor: everything sampled mid-cycle on the falling edge.
  always @(negedge clk0) begin
    if (rst_ni) begin
      if (read_clk_en_o) clk_en_cnt++;
      if (chk_mirror && read_clk_en_o) check("rx_ready_mirror", rx_ready_o, out_ready_i);
      if (out_valid_o && out_ready_i) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          want_word = exp_q.pop_front();
          check("out_word", {out_last_o, out_data_o}, want_word);
        end
      end
      if (rx_valid_i && rx_ready_o) src_pop = 1'b1;
      if (done_o) begin
        done_seen++;
        last_done_cyc = cyc;
        check("done_expected", exp_done_q.size() > 0, 1);
        if (exp_done_q.size() > 0) begin
          want_err = exp_done_q.pop_front();
          check("done_error_flag", error_o, want_err);
        end
      end
    end
  end

  task automatic drive_src();
    rx_valid_i = (src_q.size() > 0);
    rx_data_i  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
    if (src_pop) begin
      if (src_q.size() > 0) src_q.delete(0);
      src_pop = 1'b0;
    end
    if (toggle_ready) out_ready_i = ~out_ready_i;
    drive_src();
  endtask

  task automatic push_word(input logic [15:0] d, input logic last);
    src_q.push_back(d);
    exp_q.push_back({last, d});
    drive_src();
  endtask

  task automatic issue_req(input logic [LEN_W-1:0] len, input logic err);
    req_len_i   = len;
    req_valid_i = 1'b1;
    acc_cyc     = cyc;
    done_base   = done_seen;
    exp_done_q.push_back(err);
    @(negedge clk0);
    check("req_ready_at_accept", req_ready_o, 1);
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_seen != done_base) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check(tag, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while rst_ni is held low.
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_clk_en", read_clk_en_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_rx_ready", rx_ready_o, 0);
    @(posedge clk0);
    #1 rst_ni = 1'b1;
    @(negedge clk0);
    check("idle_req_ready", req_ready_o, 1);
    step();

    // Four-word burst, requester always ready.
    clk_en_cnt = 0;
    for (int i = 1; i <= 4; i++) push_word(16'(16'h1111 * i), i == 4);
    issue_req(16'd4, 1'b0);
    wait_done("t1_done");
    check("t1_done_latency", last_done_cyc - acc_cyc, 5);
    check("t1_clk_en_cycles", clk_en_cnt, 4);
    check("t1_sb_empty", exp_q.size(), 0);
    step();

    // Three-word burst with the requester toggling ready.
    toggle_ready = 1'b1;
    chk_mirror   = 1'b1;
    for (int i = 1; i <= 3; i++) push_word(16'(16'hA000 + i), i == 3);
    issue_req(16'd3, 1'b0);
    wait_done("t2_done");
    toggle_ready = 1'b0;
    chk_mirror   = 1'b0;
    out_ready_i  = 1'b1;
    check("t2_sb_empty", exp_q.size(), 0);
    check("t2_src_empty", src_q.size(), 0);
    step();

    // Zero-length request: done next cycle, capture clock never enabled.
    clk_en_cnt = 0;
    issue_req(16'd0, 1'b0);
    wait_done("t3_done");
    check("t3_done_latency", last_done_cyc - acc_cyc, 1);
    check("t3_clk_en_cycles", clk_en_cnt, 0);
    step();

    // Abort coincident with a valid word: word dropped, flush, error.
    clk_en_cnt = 0;
    push_word(16'hB001, 1'b0);
    issue_req(16'd4, 1'b1);
    step();
    src_q.push_back(16'hB002);
    drive_src();
    abort_i  = 1'b1;
    mark_cyc = cyc;
    @(negedge clk0);
    check("abort_out_valid", out_valid_o, 0);
    check("abort_rx_ready", rx_ready_o, 0);
    step();
    abort_i = 1'b0;
    @(negedge clk0);
    check("flush_rx_ready", rx_ready_o, 1);
    check("flush_clk_en", read_clk_en_o, 0);
    check("flush_req_ready", req_ready_o, 0);
    wait_done("t4_done");
    check("t4_done_latency", last_done_cyc - mark_cyc, FLUSH_CYC + 1);
    check("t4_clk_en_cycles", clk_en_cnt, 2);
    check("t4_src_drained", src_q.size(), 0);
    check("t4_sb_empty", exp_q.size(), 0);
    step();

    // Abort while idle is ignored.
    done_base = done_seen;
    abort_i = 1'b1;
    step();
    step();
    abort_i = 1'b0;
    step();
    check("idle_abort_no_done", done_seen, done_base);
    @(negedge clk0);
    check("idle_abort_ready", req_ready_o, 1);
    step();

`ifdef HYPERBUS_READ_TIMEOUT_EN
    // Only two of four words arrive: timeout after 5 idle cycles, then flush.
    cfg_timeout_i = 8'd5;
    push_word(16'hC001, 1'b0);
    push_word(16'hC002, 1'b0);
    issue_req(16'd4, 1'b1);
    wait_done("t6_done");
    check("t6_done_latency", last_done_cyc - acc_cyc, 3 + 5 + 1 + FLUSH_CYC);
    check("t6_sb_empty", exp_q.size(), 0);
    cfg_timeout_i = 8'd0;
`else
    // Long stall with a timeout configured must not end the burst early.
    cfg_timeout_i = 8'd5;
    push_word(16'hC001, 1'b0);
    issue_req(16'd2, 1'b0);
    repeat (12) step();
    check("t6_no_early_done", done_seen, done_base);
    push_word(16'hC002, 1'b1);
    wait_done("t6_done");
    check("t6_sb_empty", exp_q.size(), 0);
    cfg_timeout_i = 8'd0;
`endif
    step();

    // Reset during word 2 of 4: clock enable drops at once, no done.
    push_word(16'hD001, 1'b0);
    src_q.push_back(16'hD002);
    drive_src();
    issue_req(16'd4, 1'b0);
    step();
    rst_ni = 1'b0;
    exp_done_q.delete();
    done_base = done_seen;
    #1;
    check("mid_rst_clk_en", read_clk_en_o, 0);
    check("mid_rst_out_valid", out_valid_o, 0);
    check("mid_rst_rx_ready", rx_ready_o, 0);
    check("mid_rst_req_ready", req_ready_o, 0);
    check("mid_rst_sb_empty", exp_q.size(), 0);
    step();
    step();
    src_q.delete();
    src_pop = 1'b0;
    drive_src();
    rst_ni = 1'b1;
    step();
    check("mid_rst_no_done", done_seen, done_base);
    push_word(16'hE001, 1'b0);
    push_word(16'hE002, 1'b1);
    issue_req(16'd2, 1'b0);
    wait_done("t7_done");
    check("t7_done_latency", last_done_cyc - acc_cyc, 3);
    check("t7_sb_empty", exp_q.size(), 0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
